// File: rtl/mem_bus_arbiter.sv
// Two-master / one-slave arbiter for the picorv32-native memory bus.
// Round-robin between master 0 (CPU) and master 1 (loader/DMA), grant held
// for a whole transfer, one forced idle cycle between transfers, and a
// watchdog that aborts a transfer the slave never completes.
module mem_bus_arbiter #(
  parameter int unsigned TIMEOUT      = 64,
  parameter logic [31:0] TIMEOUT_DATA = 32'hDEAD_BEEF,
  parameter int unsigned CNT_W        = 8
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        m0_valid,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wstrb,
  output logic        m0_ready,
  output logic [31:0] m0_rdata,
  input  logic        m1_valid,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wstrb,
  output logic        m1_ready,
  output logic [31:0] m1_rdata,
  output logic        s_valid,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  output logic [3:0]  s_wstrb,
  input  logic        s_ready,
  input  logic [31:0] s_rdata,
  output logic [1:0]  grant,
  output logic        timeout_err
);

  // Watchdog disabled when TIMEOUT is zero; abort fires on count TIMEOUT-1.
  localparam logic             LP_WDOG_EN   = (TIMEOUT != 0);
  localparam logic [CNT_W-1:0] LP_WDOG_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_G0   = 2'd1,
    ST_G1   = 2'd2
  } state_t;

  state_t           r_state;
  logic             r_last;
  logic [CNT_W-1:0] r_wdog;

  logic w_g0;
  logic w_g1;
  logic w_granted;
  logic w_mvalid;
  logic w_done;
  logic w_abort;
  logic w_wdog_max;

  // Decode of current owner and transfer-ending conditions.
  assign w_g0       = (r_state == ST_G0);
  assign w_g1       = (r_state == ST_G1);
  assign w_granted  = w_g0 | w_g1;
  assign w_mvalid   = w_g1 ? m1_valid : (w_g0 & m0_valid);
  assign w_done     = w_granted & s_ready;
  assign w_abort    = LP_WDOG_EN & w_granted & w_mvalid & ~s_ready &
                      (r_wdog == LP_WDOG_LAST);
  assign w_wdog_max = &r_wdog;

  // Slave-side mux: master 0 is shown whenever master 1 is not the owner.
  assign s_valid = w_mvalid & ~w_abort;
  assign s_addr  = w_g1 ? m1_addr  : m0_addr;
  assign s_wdata = w_g1 ? m1_wdata : m0_wdata;
  assign s_wstrb = w_g1 ? m1_wstrb : m0_wstrb;

  // Master-side return path; an abort substitutes the timeout pattern.
  assign m0_ready    = w_g0 & (s_ready | w_abort);
  assign m1_ready    = w_g1 & (s_ready | w_abort);
  assign m0_rdata    = (w_g0 & w_abort) ? TIMEOUT_DATA : s_rdata;
  assign m1_rdata    = (w_g1 & w_abort) ? TIMEOUT_DATA : s_rdata;
  assign grant       = {w_g1, w_g0};
  assign timeout_err = w_abort;

  // Arbitration state, round-robin history and saturating watchdog.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state <= ST_IDLE;
      r_last  <= 1'b1;
      r_wdog  <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_wdog <= '0;
          if (m0_valid && m1_valid) begin
            r_state <= r_last ? ST_G0 : ST_G1;
          end else if (m0_valid) begin
            r_state <= ST_G0;
          end else if (m1_valid) begin
            r_state <= ST_G1;
          end
        end
        ST_G0, ST_G1: begin
          if (w_done || w_abort) begin
            r_state <= ST_IDLE;
            r_last  <= w_g1;
            r_wdog  <= '0;
          end else if (!w_mvalid) begin
            // Owner withdrew its request: release without a ready.
            r_state <= ST_IDLE;
            r_wdog  <= '0;
          end else if (!w_wdog_max) begin
            r_wdog <= r_wdog + CNT_W'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_wdog  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed-vector bench for mem_bus_arbiter (TIMEOUT=8).
module tb_mem_bus_arbiter;

  localparam logic [31:0] M0_ADDR  = 32'h0000_0010;
  localparam logic [31:0] M0_WDATA = 32'h0000_0000;
  localparam logic [3:0]  M0_WSTRB = 4'b0000;
  localparam logic [31:0] M1_ADDR  = 32'h0000_0020;
  localparam logic [31:0] M1_WDATA = 32'hCAFE_F00D;
  localparam logic [3:0]  M1_WSTRB = 4'b0011;

  logic        clk;
  logic        nrst;
  logic        m0_valid, m1_valid;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic        m0_ready, m1_ready;
  logic [31:0] m0_rdata, m1_rdata;
  logic        s_valid;
  logic [31:0] s_addr, s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_ready;
  logic [31:0] s_rdata;
  logic [1:0]  grant;
  logic        timeout_err;

  int total = 0;
  int bad   = 0;

  mem_bus_arbiter #(
    .TIMEOUT      (8),
    .TIMEOUT_DATA (32'hDEAD_BEEF),
    .CNT_W        (8)
  ) dut (
    .clk         (clk),
    .nrst        (nrst),
    .m0_valid    (m0_valid),
    .m0_addr     (m0_addr),
    .m0_wdata    (m0_wdata),
    .m0_wstrb    (m0_wstrb),
    .m0_ready    (m0_ready),
    .m0_rdata    (m0_rdata),
    .m1_valid    (m1_valid),
    .m1_addr     (m1_addr),
    .m1_wdata    (m1_wdata),
    .m1_wstrb    (m1_wstrb),
    .m1_ready    (m1_ready),
    .m1_rdata    (m1_rdata),
    .s_valid     (s_valid),
    .s_addr      (s_addr),
    .s_wdata     (s_wdata),
    .s_wstrb     (s_wstrb),
    .s_ready     (s_ready),
    .s_rdata     (s_rdata),
    .grant       (grant),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        m0v;
    logic        m1v;
    logic        sr;
    logic [31:0] srd;
    logic [1:0]  gnt;
    logic        sv;
    logic        m0r;
    logic        m1r;
    logic        terr;
    logic [31:0] rd;
  } vec_t;

  vec_t vecs [26];

  function automatic vec_t mkv(input logic m0v, input logic m1v, input logic sr,
                               input logic [31:0] srd, input logic [1:0] gnt,
                               input logic sv, input logic m0r, input logic m1r,
                               input logic terr, input logic [31:0] rd);
    vec_t v;
    v.m0v = m0v; v.m1v = m1v; v.sr = sr; v.srd = srd;
    v.gnt = gnt; v.sv = sv; v.m0r = m0r; v.m1r = m1r; v.terr = terr; v.rd = rd;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check_vec(input vec_t v, input string tag);
    logic        own1;
    logic [31:0] ea, ew;
    logic [3:0]  es;
    own1 = (v.gnt == 2'b10);
    ea = own1 ? M1_ADDR  : M0_ADDR;
    ew = own1 ? M1_WDATA : M0_WDATA;
    es = own1 ? M1_WSTRB : M0_WSTRB;
    chk({tag, ".grant"},    32'(grant),       32'(v.gnt));
    chk({tag, ".s_valid"},  32'(s_valid),     32'(v.sv));
    chk({tag, ".m0_ready"}, 32'(m0_ready),    32'(v.m0r));
    chk({tag, ".m1_ready"}, 32'(m1_ready),    32'(v.m1r));
    chk({tag, ".tmo_err"},  32'(timeout_err), 32'(v.terr));
    chk({tag, ".s_addr"},   s_addr,           ea);
    chk({tag, ".s_wdata"},  s_wdata,          ew);
    chk({tag, ".s_wstrb"},  32'(s_wstrb),     32'(es));
    if (v.m0r) chk({tag, ".m0_rdata"}, m0_rdata, v.rd);
    if (v.m1r) chk({tag, ".m1_rdata"}, m1_rdata, v.rd);
  endtask

  // Drive one cycle's inputs after the edge, check outputs on the falling edge.
  task automatic run(input vec_t v, input string tag);
    @(posedge clk);
    #1;
    m0_valid = v.m0v;
    m1_valid = v.m1v;
    s_ready  = v.sr;
    s_rdata  = v.srd;
    @(negedge clk);
    check_vec(v, tag);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".grant"},    32'(grant),       32'd0);
    chk({tag, ".s_valid"},  32'(s_valid),     32'd0);
    chk({tag, ".m0_ready"}, 32'(m0_ready),    32'd0);
    chk({tag, ".m1_ready"}, 32'(m1_ready),    32'd0);
    chk({tag, ".tmo_err"},  32'(timeout_err), 32'd0);
  endtask

  // Assert reset between edges, check it bites at once, release after an edge.
  task automatic apply_reset(input string tag);
    nrst = 1'b0;
    #1;
    chk_reset(tag);
    @(posedge clk);
    #2;
    nrst = 1'b1;
  endtask

  initial begin
    nrst     = 1'b0;
    m0_addr  = M0_ADDR;  m0_wdata = M0_WDATA; m0_wstrb = M0_WSTRB;
    m1_addr  = M1_ADDR;  m1_wdata = M1_WDATA; m1_wstrb = M1_WSTRB;
    m0_valid = 1'b1;
    m1_valid = 1'b1;
    s_ready  = 1'b1;
    s_rdata  = 32'h0;

    // Single read by m0, ready one cycle after s_valid.
    vecs[0]  = mkv(1, 0, 0, 32'h0,         2'b00, 0, 0, 0, 0, 32'h0);
    vecs[1]  = mkv(1, 0, 0, 32'h0,         2'b01, 1, 0, 0, 0, 32'h0);
    vecs[2]  = mkv(1, 0, 1, 32'h1234_5678, 2'b01, 1, 1, 0, 0, 32'h1234_5678);
    vecs[3]  = mkv(0, 0, 0, 32'h0,         2'b00, 0, 0, 0, 0, 32'h0);
    // m1 write, mux shows m1 for the whole grant.
    vecs[4]  = mkv(0, 1, 0, 32'h0,         2'b00, 0, 0, 0, 0, 32'h0);
    vecs[5]  = mkv(0, 1, 0, 32'h0,         2'b10, 1, 0, 0, 0, 32'h0);
    vecs[6]  = mkv(0, 1, 1, 32'hA5A5_0000, 2'b10, 1, 0, 1, 0, 32'hA5A5_0000);
    vecs[7]  = mkv(0, 0, 0, 32'h0,         2'b00, 0, 0, 0, 0, 32'h0);
    // Continuous contention: 01,10,01,10,01,10 with one idle cycle between.
    vecs[8]  = mkv(1, 1, 0, 32'h0,         2'b00, 0, 0, 0, 0, 32'h0);
    vecs[9]  = mkv(1, 1, 1, 32'h1111_1111, 2'b01, 1, 1, 0, 0, 32'h1111_1111);
    vecs[10] = mkv(1, 1, 0, 32'h0,         2'b00, 0, 0, 0, 0, 32'h0);
    vecs[11] = mkv(1, 1, 1, 32'h2222_2222, 2'b10, 1, 0, 1, 0, 32'h2222_2222);
    vecs[12] = mkv(1, 1, 0, 32'h0,         2'b00, 0, 0, 0, 0, 32'h0);
    vecs[13] = mkv(1, 1, 1, 32'h3333_3333, 2'b01, 1, 1, 0, 0, 32'h3333_3333);
    vecs[14] = mkv(1, 1, 0, 32'h0,         2'b00, 0, 0, 0, 0, 32'h0);
    vecs[15] = mkv(1, 1, 1, 32'h4444_4444, 2'b10, 1, 0, 1, 0, 32'h4444_4444);
    vecs[16] = mkv(1, 1, 0, 32'h0,         2'b00, 0, 0, 0, 0, 32'h0);
    vecs[17] = mkv(1, 1, 1, 32'h5555_5555, 2'b01, 1, 1, 0, 0, 32'h5555_5555);
    vecs[18] = mkv(1, 1, 0, 32'h0,         2'b00, 0, 0, 0, 0, 32'h0);
    vecs[19] = mkv(1, 1, 1, 32'h6666_6666, 2'b10, 1, 0, 1, 0, 32'h6666_6666);
    vecs[20] = mkv(0, 0, 0, 32'h0,         2'b00, 0, 0, 0, 0, 32'h0);
    // m0 drops valid mid-grant: no ready, round-robin history untouched.
    vecs[21] = mkv(1, 0, 0, 32'h0,         2'b00, 0, 0, 0, 0, 32'h0);
    vecs[22] = mkv(0, 0, 0, 32'h0,         2'b01, 0, 0, 0, 0, 32'h0);
    vecs[23] = mkv(1, 1, 0, 32'h0,         2'b00, 0, 0, 0, 0, 32'h0);
    vecs[24] = mkv(1, 1, 1, 32'h7777_7777, 2'b01, 1, 1, 0, 0, 32'h7777_7777);
    vecs[25] = mkv(0, 0, 0, 32'h0,         2'b00, 0, 0, 0, 0, 32'h0);

    #12;
    chk_reset("reset");
    m0_valid = 1'b0;
    m1_valid = 1'b0;
    s_ready  = 1'b0;
    #10;
    nrst = 1'b1;

    for (int i = 0; i < 26; i++) begin
      run(vecs[i], $sformatf("vec%0d", i));
    end

    // Watchdog abort on the 8th granted cycle.
    run(mkv(1, 0, 0, 32'h0, 2'b00, 0, 0, 0, 0, 32'h0), "to.req");
    for (int g = 1; g <= 7; g++) begin
      run(mkv(1, 0, 0, 32'h0, 2'b01, 1, 0, 0, 0, 32'h0), $sformatf("to.wait%0d", g));
    end
    run(mkv(1, 0, 0, 32'h0, 2'b01, 0, 1, 0, 1, 32'hDEAD_BEEF), "to.abort");
    run(mkv(0, 0, 0, 32'h0, 2'b00, 0, 0, 0, 0, 32'h0), "to.after");

    // Slave ready on the last watchdog cycle wins over the abort.
    run(mkv(1, 0, 0, 32'h0, 2'b00, 0, 0, 0, 0, 32'h0), "tr.req");
    for (int g = 1; g <= 7; g++) begin
      run(mkv(1, 0, 0, 32'h0, 2'b01, 1, 0, 0, 0, 32'h0), $sformatf("tr.wait%0d", g));
    end
    run(mkv(1, 0, 1, 32'h55AA_55AA, 2'b01, 1, 1, 0, 0, 32'h55AA_55AA), "tr.done");
    run(mkv(0, 0, 0, 32'h0, 2'b00, 0, 0, 0, 0, 32'h0), "tr.after");

    // Reset while G1 waits on the slave; ready arriving then must be lost.
    run(mkv(0, 1, 0, 32'h0, 2'b00, 0, 0, 0, 0, 32'h0), "rm.req");
    run(mkv(0, 1, 0, 32'h0, 2'b10, 1, 0, 0, 0, 32'h0), "rm.wait1");
    run(mkv(0, 1, 0, 32'h0, 2'b10, 1, 0, 0, 0, 32'h0), "rm.wait2");
    #2;
    s_ready = 1'b1;
    s_rdata = 32'hBAAD_0001;
    apply_reset("rm.reset");
    s_ready = 1'b0;
    run(mkv(0, 1, 0, 32'h0, 2'b10, 1, 0, 0, 0, 32'h0), "rm.regrant");
    run(mkv(0, 1, 1, 32'h9ABC_DEF0, 2'b10, 1, 0, 1, 0, 32'h9ABC_DEF0), "rm.done");
    run(mkv(0, 0, 0, 32'h0, 2'b00, 0, 0, 0, 0, 32'h0), "rm.after");

    // m0 transfer so the history points at m0, then reset restores m0 priority.
    run(mkv(1, 0, 0, 32'h0, 2'b00, 0, 0, 0, 0, 32'h0), "cr.m0req");
    run(mkv(1, 0, 1, 32'h0F0F_0F0F, 2'b01, 1, 1, 0, 0, 32'h0F0F_0F0F), "cr.m0done");
    run(mkv(0, 0, 0, 32'h0, 2'b00, 0, 0, 0, 0, 32'h0), "cr.idle");
    #2;
    m0_valid = 1'b1;
    m1_valid = 1'b1;
    apply_reset("cr.reset");
    run(mkv(1, 1, 0, 32'h0, 2'b01, 1, 0, 0, 0, 32'h0), "cr.g0");
    run(mkv(1, 1, 1, 32'hC0FF_EE00, 2'b01, 1, 1, 0, 0, 32'hC0FF_EE00), "cr.g0done");
    run(mkv(1, 1, 0, 32'h0, 2'b00, 0, 0, 0, 0, 32'h0), "cr.gap");
    run(mkv(1, 1, 0, 32'h0, 2'b10, 1, 0, 0, 0, 32'h0), "cr.g1");
    run(mkv(1, 1, 1, 32'hD00D_FEED, 2'b10, 1, 0, 1, 0, 32'hD00D_FEED), "cr.g1done");
    run(mkv(0, 0, 0, 32'h0, 2'b00, 0, 0, 0, 0, 32'h0), "cr.end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Two-master, one-slave arbiter for the picorv32-native memory bus (valid/ready/addr/wdata/wstrb/rdata).
- Lets the CPU and a second bus master (debug loader or DMA) share the single BRAM memory controller.
- Uses round-robin arbitration, holds the grant for a whole transfer, and has a watchdog timeout so a stalled slave cannot hang either master.

Parameters:
- TIMEOUT, 64, cycles of granted s_valid without s_ready before the arbiter aborts the transfer; 0 disables the watchdog.
- TIMEOUT_DATA, 32'hDEAD_BEEF, rdata returned to the master on an aborted transfer.
- CNT_W, 8, width of the watchdog counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  system clock.
- nrst  in  1  reset, asynchronous, active-low.
- m0_valid, m1_valid  in  1  request from master 0 (CPU) / master 1.
- m0_addr, m1_addr  in  32  byte address.
- m0_wdata, m1_wdata  in  32  write data.
- m0_wstrb, m1_wstrb  in  4  byte write strobes; 0 means read.
- m0_ready, m1_ready  out  1  transfer-complete pulse to each master.
- m0_rdata, m1_rdata  out  32  read data, valid while the matching ready is high.
- s_valid  out  1  request to the slave (memcontroller_bram).
- s_addr  out  32  muxed address to the slave.
- s_wdata  out  32  muxed write data to the slave.
- s_wstrb  out  4  muxed write strobes to the slave.
- s_ready  in  1  slave completion.
- s_rdata  in  32  slave read data.
- grant  out  2  one-hot current owner; 00 when idle.
- timeout_err  out  1  one-cycle pulse when a transfer is aborted.

Behaviour:
- Reset (async, nrst=0):
  - state=IDLE, last=1 (master 0 wins the first tie), wdog=0.
  - s_valid=0, m0_ready=m1_ready=0, grant=00, timeout_err=0.
  - These take effect immediately, even mid-transfer. The slave sees s_valid drop; any in-flight ready is lost.
- States: IDLE, G0, G1. All decisions are registered on posedge clk.
- IDLE:
  - Only m0_valid → G0. Only m1_valid → G1.
  - Both valid → grant the master ≠ last.
  - Neither valid → stay in IDLE.
  - s_valid=0 in IDLE, and the s_* mux shows master 0's signals.
- Gn (n = 0 or 1):
  - grant is one-hot n.
  - s_valid = mn_valid. s_addr, s_wdata and s_wstrb are taken from master n (combinational mux).
  - Every cycle, mn_rdata = s_rdata (combinational). The other master's ready is 0.
- Completion: s_ready=1 while in Gn →
  - mn_ready=1 in the same cycle (combinational).
  - Next state is IDLE, last=n, wdog cleared.
- Idle cycle between transfers:
  - Exactly one IDLE cycle with s_valid=0 follows every transfer.
  - This guarantees the slave sees valid low between accesses and lets the master drop valid.
  - Minimum transfer: request at cycle t, s_valid at t+1, ready at t+1 at the earliest, next grant at t+3.
- Watchdog (TIMEOUT>0):
  - wdog counts up each cycle in Gn with s_ready=0.
  - When wdog reaches TIMEOUT-1 and s_ready is still 0, that cycle produces:
    - mn_ready=1 and mn_rdata=TIMEOUT_DATA;
    - s_valid forced 0 and timeout_err=1;
    - next state IDLE, last=n.
  - If s_ready=1 arrives in that same cycle, normal completion wins: no error, slave data is returned.
- Master drops mn_valid while granted, before ready (protocol violation):
  - s_valid follows it low.
  - Next state IDLE with no ready and last unchanged.
- Fairness: with both masters requesting continuously, grants strictly alternate 0,1,0,1.
- The non-granted master's request is held pending; the arbiter never issues ready to a master it has not granted.
- Width rules:
  - wdog saturates; it never wraps.
  - Address and data are passed through unmodified, with no decoding.

Test Plan:
- Single read: m0 reads addr 0x10; slave returns ready one cycle after s_valid with rdata 0x1234_5678 → m0_ready pulses 1 cycle with rdata 0x1234_5678; grant goes 01→00; m1_ready stays 0.
- Contention: m0 and m1 both assert valid in the same cycle from reset → m0 is served first, then m1; with both continuously requesting for 6 transfers, the grant sequence is 01,10,01,10,01,10.
- Write mux: m1 writes 0xCAFE_F00D with wstrb 4'b0011 to 0x20 while m0 is idle → s_addr=0x20, s_wdata=0xCAFE_F00D, s_wstrb=0011 for the whole grant.
- Timeout: with TIMEOUT=8, the slave never asserts ready for an m0 request → on the 8th granted cycle m0_ready=1, m0_rdata=0xDEADBEEF, timeout_err=1; the following cycle s_valid=0.
- Ready on the timeout cycle: s_ready arrives exactly on wdog=TIMEOUT-1 → normal completion; timeout_err=0; slave rdata is returned.
- Reset mid-transfer: drop nrst while G1 is waiting for the slave → s_valid, m1_ready and grant go to 0 asynchronously; after release, a new m1 request is granted normally.
